tick_pwm_gen: RTL

//   Consumer of the freq_divider output. Brings the divided clock (clock_out) into the

---
 rtl/tick_pwm_gen.sv | 98 +++++++++
 1 files changed

// File: rtl/tick_pwm_gen.sv
// Brings a divided clock into the clock_in domain as data, turns its rising edges into ticks,
// and steps a PWM with a duty value shadowed once per period.
module tick_pwm_gen #(
  parameter int unsigned     SYNC_STAGES = 2,
  parameter int unsigned     CW          = 10,
  parameter logic [CW-1:0]   PERIOD      = 10'd100
) (
  input  logic          clock_in,
  input  logic          reset,
  input  logic          div_clock,
  input  logic          enable,
  input  logic [CW-1:0] duty,
  output logic          tick,
  output logic          period_start,
  output logic          pwm_out,
  output logic [CW-1:0] duty_active
);

  localparam int unsigned   ArmCount  = SYNC_STAGES + 1;
  localparam int unsigned   AW        = $clog2(ArmCount + 1);
  localparam logic [AW-1:0] ArmLast   = AW'(ArmCount);
  localparam logic [CW-1:0] LastPhase = PERIOD - 1'b1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [AW-1:0]          arm_cnt_q;
  logic [CW-1:0]          phase_q;

  logic          armed;
  logic          tick_d;
  logic          wrap;
  logic [CW-1:0] duty_sat;
  logic [CW-1:0] phase_next;

  always_comb begin
    armed      = (arm_cnt_q == ArmLast);
    // Gated by armed so a level already high at reset release is not seen as an edge.
    tick_d     = sync_q[SYNC_STAGES-1] & ~prev_q & armed;
    wrap       = (phase_q == LastPhase);
    duty_sat   = (duty >= PERIOD) ? PERIOD : duty;
    phase_next = wrap ? '0 : phase_q + 1'b1;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      arm_cnt_q    <= '0;
      tick         <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
      duty_active  <= '0;
      phase_q      <= '0;
      state_q      <= StIdle;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], div_clock};
      prev_q       <= sync_q[SYNC_STAGES-1];
      if (!armed) arm_cnt_q <= arm_cnt_q + 1'b1;
      tick         <= tick_d;
      period_start <= 1'b0;

      case (state_q)
        StIdle: begin
          pwm_out <= 1'b0;
          phase_q <= '0;
          if (tick_d && enable) begin
            state_q      <= StRun;
            duty_active  <= duty_sat;
            period_start <= 1'b1;
            pwm_out      <= (duty_sat != '0);
          end
        end
        StRun: begin
          if (!enable) begin
            // Dropping enable wins over a coincident tick; duty_active keeps its last value.
            state_q <= StIdle;
            pwm_out <= 1'b0;
            phase_q <= '0;
          end else if (tick_d) begin
            phase_q <= phase_next;
            if (wrap) begin
              duty_active  <= duty_sat;
              period_start <= 1'b1;
              pwm_out      <= (phase_next < duty_sat);
            end else begin
              pwm_out      <= (phase_next < duty_active);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
